payload_engine_seq: RTL and testbench

- Sequences one bank of `NUM_ENG` payload-matching engines. Each engine is a chain of char-gated flops with a shared `sod` clear, a shared `en` enable and a sticky single-bit `out`.
- Per packet, the block does four things:
  - clears the bank,
  - gates the payload byte stream into it,
  - flushes the pipeline,
  - reports matching engine indices one at a time over a valid/ready handshake.
- Sits between the payload byte source/char-class decoder and the alert/rule-ID formatter.

---
 rtl/payload_engine_seq_pkg.sv | 27 ++
 rtl/payload_engine_seq_lowbit_pri_enc.sv | 32 +++
 rtl/payload_engine_seq.sv | 145 ++++++++++++++
 tb/tb_payload_engine_seq.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/payload_engine_seq_pkg.sv
// Shared types and helpers for the payload engine bank sequencer.
// Holds the FSM state encoding, the default drain length and a popcount.
package payload_engine_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_CAPTURE,
        ST_REPORT,
        ST_DONE
    } state_t;

    localparam int unsigned DRAIN_CYCLES_DEF = 2;
    localparam int unsigned POP_MAX_W        = 64;

    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < POP_MAX_W; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/payload_engine_seq_lowbit_pri_enc.sv
// Lowest-set-bit priority encoder: index of the lowest set bit plus
// flags for "any bit set" and "exactly one bit set".
module lowbit_pri_enc
    import payload_engine_seq_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned IDX_W = 6
) (
    input  logic [W-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             single
);

    logic found;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            if (vec[i] && !found) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

    assign any    = |vec;
    // x & (x-1) strips the lowest set bit; nothing left means one bit was set.
    assign single = any && ((vec & (vec - W'(1))) == '0);

endmodule

// File: rtl/payload_engine_seq.sv
// Per-packet sequencer for a bank of payload-matching engines: clear, stream,
// drain, capture the match vector and report matching engine indices.
module payload_engine_seq
    import payload_engine_seq_pkg::*;
#(
    parameter int unsigned NUM_ENG      = 16,
    parameter int unsigned ID_W         = 6,
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    input  logic                         s_sof,
    input  logic                         s_eof,
    output logic                         s_ready,
    output logic                         eng_sod,
    output logic                         eng_en,
    output logic                         char_gate,
    input  logic [NUM_ENG-1:0]           eng_match,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [ID_W-1:0]              m_id,
    output logic                         m_last,
    output logic                         pkt_done,
    output logic                         pkt_abort,
    output logic [$clog2(NUM_ENG+1)-1:0] match_cnt
);

    localparam int unsigned CNT_W = $clog2(NUM_ENG + 1);
    localparam int unsigned DC_W  = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    state_t              state, state_nx;
    logic [NUM_ENG-1:0]  vec, vec_nx;
    logic [DC_W-1:0]     drain_cnt, drain_nx;
    logic                first_beat, first_nx;
    logic                sod_st;
    logic [ID_W-1:0]     low_idx;
    logic                vec_any, vec_single;

    lowbit_pri_enc #(
        .W     (NUM_ENG),
        .IDX_W (ID_W)
    ) u_enc (
        .vec    (vec),
        .idx    (low_idx),
        .any    (vec_any),
        .single (vec_single)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            vec        <= '0;
            drain_cnt  <= '0;
            first_beat <= 1'b0;
            match_cnt  <= '0;
        end else begin
            state      <= state_nx;
            vec        <= vec_nx;
            drain_cnt  <= drain_nx;
            first_beat <= first_nx;
            if (state == ST_CAPTURE) begin
                match_cnt <= CNT_W'(popcount(POP_MAX_W'(eng_match)));
            end
        end
    end

    always_comb begin
        state_nx  = state;
        vec_nx    = vec;
        drain_nx  = drain_cnt;
        first_nx  = first_beat;
        s_ready   = 1'b0;
        sod_st    = 1'b0;
        eng_en    = 1'b0;
        char_gate = 1'b0;
        m_valid   = 1'b0;
        m_last    = 1'b0;
        pkt_done  = 1'b0;
        pkt_abort = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (s_valid) begin
                    if (s_sof) state_nx = ST_CLEAR;
                    else       s_ready  = 1'b1;
                end
            end
            ST_CLEAR: begin
                sod_st   = 1'b1;
                first_nx = 1'b1;
                state_nx = ST_STREAM;
            end
            ST_STREAM: begin
                char_gate = 1'b1;
                eng_en    = s_valid;
                // A fresh sof mid-packet is stalled and restarts the bank.
                if (s_valid && s_sof && !s_eof && !first_beat) begin
                    pkt_abort = 1'b1;
                    state_nx  = ST_CLEAR;
                end else begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        first_nx = 1'b0;
                        if (s_eof) begin
                            drain_nx = DC_W'(DRAIN_CYCLES);
                            state_nx = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                eng_en   = 1'b1;
                drain_nx = drain_cnt - DC_W'(1);
                if (drain_cnt <= DC_W'(1)) state_nx = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                vec_nx   = eng_match;
                state_nx = ST_REPORT;
            end
            ST_REPORT: begin
                if (!vec_any) begin
                    state_nx = ST_DONE;
                end else begin
                    m_valid = 1'b1;
                    m_last  = vec_single;
                    if (m_ready) begin
                        vec_nx = vec & (vec - NUM_ENG'(1));
                        if (vec_single) state_nx = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                pkt_done = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Engines are held clear for the whole time reset is asserted.
    assign eng_sod = sod_st | ~rst_n;
    assign m_id    = low_idx;

endmodule

// File: tb/tb_payload_engine_seq.sv
// Self-checking bench for payload_engine_seq with a queue-based report model.
// Inputs change 1 time unit after posedge; outputs are sampled 1 unit later.
module tb_payload_engine_seq;

    localparam int unsigned NUM_ENG = 16;
    localparam int unsigned ID_W    = 6;
    localparam int unsigned CNT_W   = $clog2(NUM_ENG + 1);

    logic               clk = 1'b0;
    logic               rst_n;
    logic               s_valid, s_sof, s_eof, s_ready;
    logic               eng_sod, eng_en, char_gate;
    logic [NUM_ENG-1:0] eng_match;
    logic               m_valid, m_ready, m_last;
    logic [ID_W-1:0]    m_id;
    logic               pkt_done, pkt_abort;
    logic [CNT_W-1:0]   match_cnt;

    payload_engine_seq #(
        .NUM_ENG      (NUM_ENG),
        .ID_W         (ID_W),
        .DRAIN_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_sof     (s_sof),
        .s_eof     (s_eof),
        .s_ready   (s_ready),
        .eng_sod   (eng_sod),
        .eng_en    (eng_en),
        .char_gate (char_gate),
        .eng_match (eng_match),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_id      (m_id),
        .m_last    (m_last),
        .pkt_done  (pkt_done),
        .pkt_abort (pkt_abort),
        .match_cnt (match_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int en_cnt = 0, sod_cnt = 0, mv_cnt = 0, last_sod_lbl = -1;
    always @(negedge clk) begin
        if (eng_en) en_cnt++;
        if (eng_sod && rst_n) begin
            sod_cnt++;
            last_sod_lbl = cyc;
        end
        if (m_valid) mv_cnt++;
    end

    int total = 0;
    int bad   = 0;

    // Reference model: reports are the set bits of the captured vector, ascending.
    int unsigned exp_ids[$];
    function automatic void build_exp(input logic [NUM_ENG-1:0] v);
        exp_ids.delete();
        for (int i = 0; i < NUM_ENG; i++) if (v[i]) exp_ids.push_back(i);
    endfunction

    int unsigned obs_ids[$];
    bit          obs_last[$];
    int          obs_lbl[$];
    int hold_err, first_lbl, eof_lbl, done_lbl, en_delta, sod_delta, mv_delta;
    bit timeout;

    task automatic present_beat(input logic sof, input logic eof, output int lbl);
        bit acc;
        s_valid = 1'b1; s_sof = sof; s_eof = eof;
        acc = 1'b0; lbl = -1;
        for (int t = 0; t < 20 && !acc; t++) begin
            #1;
            if (s_ready) begin
                acc = 1'b1;
                lbl = cyc;
            end
            @(posedge clk); #1;
        end
        if (!acc) timeout = 1'b1;
        s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0;
    endtask

    // mode 0: m_ready always 1; 1: random; 2: low for 3 valid cycles, then toggling
    task automatic collect(input int mode);
        int rcyc;
        bit hold;
        logic [ID_W-1:0] hid;
        logic hl;
        hold = 1'b0; rcyc = 0; hid = '0; hl = 1'b0; done_lbl = -1;
        for (int t = 0; t < 200; t++) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = (rcyc < 3) ? 1'b0 : 1'(rcyc % 2);
            endcase
            #1;
            if (m_valid) begin
                if (hold && (m_id !== hid || m_last !== hl)) hold_err++;
                if (m_ready) begin
                    obs_ids.push_back(int'(m_id));
                    obs_last.push_back(m_last);
                    obs_lbl.push_back(cyc);
                    hold = 1'b0;
                end else begin
                    hold = 1'b1; hid = m_id; hl = m_last;
                end
                rcyc++;
                eng_match = NUM_ENG'($urandom);
            end
            if (pkt_done) done_lbl = cyc;
            @(posedge clk); #1;
            if (done_lbl >= 0) break;
        end
        if (done_lbl < 0) timeout = 1'b1;
        m_ready = 1'b0;
    endtask

    task automatic run_packet(input int n, input logic [NUM_ENG-1:0] v, input int mode);
        int en0, sod0, mv0, lbl;
        en0 = en_cnt; sod0 = sod_cnt; mv0 = mv_cnt;
        obs_ids.delete(); obs_last.delete(); obs_lbl.delete();
        hold_err = 0; timeout = 1'b0; first_lbl = -1; eof_lbl = -1;
        eng_match = v;
        build_exp(v);
        for (int i = 0; i < n; i++) begin
            present_beat(i == 0, i == n - 1, lbl);
            if (i == 0) first_lbl = lbl;
            if (i == n - 1) eof_lbl = lbl;
        end
        collect(mode);
        en_delta = en_cnt - en0; sod_delta = sod_cnt - sod0; mv_delta = mv_cnt - mv0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_eof = 1'b0;
        m_ready = 1'b0; eng_match = '0;
        #1;
        total++; if (eng_sod !== 1'b1) begin bad++; $display("FAIL reset_sod got=%b exp=1", eng_sod); end
        total++; if ({s_ready, eng_en, char_gate, m_valid, m_last, pkt_done, pkt_abort} !== 7'b0) begin
            bad++; $display("FAIL reset_outs got=%b exp=0000000", {s_ready, eng_en, char_gate, m_valid, m_last, pkt_done, pkt_abort});
        end
        total++; if (match_cnt !== '0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", match_cnt); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_no_match;
        run_packet(5, '0, 0);
        total++; if (timeout) begin bad++; $display("FAIL nomatch_timeout got=1 exp=0"); end
        total++; if (sod_delta !== 1) begin bad++; $display("FAIL nomatch_sod_cycles got=%0d exp=1", sod_delta); end
        total++; if (last_sod_lbl !== first_lbl - 1) begin bad++; $display("FAIL nomatch_sod_pos got=%0d exp=%0d", last_sod_lbl, first_lbl - 1); end
        total++; if (en_delta !== 7) begin bad++; $display("FAIL nomatch_en_cycles got=%0d exp=7", en_delta); end
        total++; if (mv_delta !== 0) begin bad++; $display("FAIL nomatch_mvalid got=%0d exp=0", mv_delta); end
        total++; if (done_lbl - eof_lbl !== 5) begin bad++; $display("FAIL nomatch_latency got=%0d exp=5", done_lbl - eof_lbl); end
        total++; if (match_cnt !== 0) begin bad++; $display("FAIL nomatch_cnt got=%0d exp=0", match_cnt); end
    endtask

    task automatic test_ids;
        run_packet(3, 16'h8025, 0);
        total++; if (obs_ids.size() !== 4) begin bad++; $display("FAIL ids_count got=%0d exp=4", obs_ids.size()); end
        for (int i = 0; i < obs_ids.size() && i < exp_ids.size(); i++) begin
            total++; if (obs_ids[i] !== exp_ids[i]) begin bad++; $display("FAIL ids_seq[%0d] got=%0d exp=%0d", i, obs_ids[i], exp_ids[i]); end
            total++; if (obs_last[i] !== (i == exp_ids.size() - 1)) begin bad++; $display("FAIL ids_last[%0d] got=%b", i, obs_last[i]); end
            if (i > 0) begin
                total++; if (obs_lbl[i] !== obs_lbl[i-1] + 1) begin bad++; $display("FAIL ids_throughput[%0d] got=%0d exp=%0d", i, obs_lbl[i], obs_lbl[i-1] + 1); end
            end
        end
        total++; if (match_cnt !== 4) begin bad++; $display("FAIL ids_cnt got=%0d exp=4", match_cnt); end
    endtask

    task automatic test_backpressure;
        run_packet(2, 16'h8025, 2);
        total++; if (timeout) begin bad++; $display("FAIL bp_timeout got=1 exp=0"); end
        total++; if (hold_err !== 0) begin bad++; $display("FAIL bp_hold got=%0d exp=0", hold_err); end
        total++; if (obs_ids.size() !== exp_ids.size()) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", obs_ids.size(), exp_ids.size()); end
        for (int i = 0; i < obs_ids.size() && i < exp_ids.size(); i++) begin
            total++; if (obs_ids[i] !== exp_ids[i]) begin bad++; $display("FAIL bp_seq[%0d] got=%0d exp=%0d", i, obs_ids[i], exp_ids[i]); end
        end
    endtask

    task automatic test_single_beat;
        run_packet(1, '0, 0);
        total++; if (timeout) begin bad++; $display("FAIL single_timeout got=1 exp=0"); end
        total++; if (last_sod_lbl !== first_lbl - 1) begin bad++; $display("FAIL single_sod_pos got=%0d exp=%0d", last_sod_lbl, first_lbl - 1); end
        total++; if (en_delta !== 3) begin bad++; $display("FAIL single_en_cycles got=%0d exp=3", en_delta); end
        total++; if (done_lbl - eof_lbl !== 5) begin bad++; $display("FAIL single_latency got=%0d exp=5", done_lbl - eof_lbl); end
    endtask

    task automatic test_abort;
        int lbl;
        timeout = 1'b0;
        eng_match = 16'h0041;
        build_exp(16'h0041);
        present_beat(1'b1, 1'b0, lbl);
        present_beat(1'b0, 1'b0, lbl);
        s_valid = 1'b1; s_sof = 1'b1; s_eof = 1'b0;
        #1;
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL abort_stall got=%b exp=0", s_ready); end
        total++; if (pkt_abort !== 1'b1) begin bad++; $display("FAIL abort_pulse got=%b exp=1", pkt_abort); end
        @(posedge clk); #2;
        total++; if (eng_sod !== 1'b1) begin bad++; $display("FAIL abort_sod got=%b exp=1", eng_sod); end
        total++; if (pkt_abort !== 1'b0) begin bad++; $display("FAIL abort_pulse_width got=%b exp=0", pkt_abort); end
        @(posedge clk); #2;
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL abort_restart_accept got=%b exp=1", s_ready); end
        @(posedge clk); #1;
        present_beat(1'b0, 1'b1, lbl);
        obs_ids.delete(); obs_last.delete(); obs_lbl.delete(); hold_err = 0;
        collect(0);
        total++; if (timeout) begin bad++; $display("FAIL abort_timeout got=1 exp=0"); end
        total++; if (match_cnt !== CNT_W'(exp_ids.size())) begin bad++; $display("FAIL abort_cnt got=%0d exp=%0d", match_cnt, exp_ids.size()); end
    endtask

    task automatic test_random;
        logic [NUM_ENG-1:0] v;
        int n, mode;
        for (int k = 0; k < 25; k++) begin
            n = $urandom_range(1, 6);
            v = ($urandom_range(0, 3) == 0) ? '0 : NUM_ENG'($urandom);
            mode = $urandom_range(0, 1);
            run_packet(n, v, mode);
            total++; if (timeout || hold_err !== 0) begin bad++; $display("FAIL rand%0d_proto timeout=%b hold_err=%0d", k, timeout, hold_err); end
            total++; if (obs_ids != exp_ids) begin bad++; $display("FAIL rand%0d_ids got=%p exp=%p", k, obs_ids, exp_ids); end
            for (int i = 0; i < obs_last.size(); i++) begin
                total++; if (obs_last[i] !== (i == exp_ids.size() - 1)) begin bad++; $display("FAIL rand%0d_last[%0d] got=%b", k, i, obs_last[i]); end
            end
            total++; if (match_cnt !== CNT_W'(exp_ids.size())) begin bad++; $display("FAIL rand%0d_cnt got=%0d exp=%0d", k, match_cnt, exp_ids.size()); end
            total++; if (en_delta !== n + 2) begin bad++; $display("FAIL rand%0d_en got=%0d exp=%0d", k, en_delta, n + 2); end
            if (v == '0) begin
                total++; if (done_lbl - eof_lbl !== 5) begin bad++; $display("FAIL rand%0d_latency got=%0d exp=5", k, done_lbl - eof_lbl); end
            end
        end
    endtask

    task automatic test_reset_mid_report;
        int lbl;
        bit seen;
        timeout = 1'b0;
        eng_match = 16'h8025;
        present_beat(1'b1, 1'b0, lbl);
        present_beat(1'b0, 1'b1, lbl);
        m_ready = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            #1;
            if (m_valid) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        total++; if (!seen) begin bad++; $display("FAIL rstmid_reach got=0 exp=1"); end
        rst_n = 1'b0;
        #1;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rstmid_mvalid got=%b exp=0", m_valid); end
        total++; if (eng_sod !== 1'b1) begin bad++; $display("FAIL rstmid_sod got=%b exp=1", eng_sod); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #2;
        total++; if (s_ready !== 1'b0 || eng_sod !== 1'b0) begin bad++; $display("FAIL rstmid_idle s_ready=%b sod=%b exp=0,0", s_ready, eng_sod); end
        total++; if (match_cnt !== 0) begin bad++; $display("FAIL rstmid_cnt got=%0d exp=0", match_cnt); end
        s_valid = 1'b1; s_sof = 1'b0;
        #1;
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rstmid_idle_drop got=%b exp=1", s_ready); end
        s_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_no_match();
        test_ids();
        test_backpressure();
        test_single_beat();
        test_abort();
        test_random();
        test_reset_mid_report();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
